// File: rtl/ts_out_stub_z_window_seq_if.sv
// Bus bundle for the outer-layer stub z-window sequencer: buffer load, scan control,
// compare-stage handoff and hit reporting. TS_Z_SCAN_HIT_CNT_EN adds hit_cnt.
interface ts_out_stub_z_window_seq_if #(
  parameter int unsigned Z_BITS   = 12,
  parameter int unsigned IDX_BITS = 4
);
  logic                       clr;
  logic                       wr_en;
  logic signed [Z_BITS-1:0]   wr_dat;
  logic                       full;
  logic                       ovf;
  logic [IDX_BITS:0]          count;
  logic                       start;
  logic signed [Z_BITS-1:0]   lim_high;
  logic signed [Z_BITS-1:0]   lim_low;
  logic                       busy;
  logic                       cmp_valid;
  logic signed [Z_BITS-1:0]   cmp_stub;
  logic signed [Z_BITS-1:0]   cmp_lim_high;
  logic signed [Z_BITS-1:0]   cmp_lim_low;
  logic                       cmp_match;
  logic                       hit_valid;
  logic [IDX_BITS-1:0]        hit_idx;
  logic                       done;
`ifdef TS_Z_SCAN_HIT_CNT_EN
  logic [IDX_BITS:0]          hit_cnt;
`endif

  modport slave (
    input  clr, wr_en, wr_dat, start, lim_high, lim_low, cmp_match,
    output full, ovf, count, busy, cmp_valid, cmp_stub, cmp_lim_high, cmp_lim_low,
           hit_valid, hit_idx, done
`ifdef TS_Z_SCAN_HIT_CNT_EN
    , output hit_cnt
`endif
  );

  modport master (
    output clr, wr_en, wr_dat, start, lim_high, lim_low, cmp_match,
    input  full, ovf, count, busy, cmp_valid, cmp_stub, cmp_lim_high, cmp_lim_low,
           hit_valid, hit_idx, done
`ifdef TS_Z_SCAN_HIT_CNT_EN
    , input hit_cnt
`endif
  );
endinterface

// File: rtl/ts_out_stub_z_window_seq.sv
// Buffers one event's outer-layer stub z values, streams them to the z-compare stage per
// inner-stub window and realigns the returned match bits to buffer indices.
// Optional hit counter output enabled by TS_Z_SCAN_HIT_CNT_EN.
module ts_out_stub_z_window_seq #(
  parameter int unsigned Z_BITS   = 12,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned IDX_BITS = 4
) (
  input logic                        clk,
  input logic                        reset,
  ts_out_stub_z_window_seq_if.slave  bus
);
  localparam int unsigned CNT_W = IDX_BITS + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t                    state, state_nx;
  logic signed [Z_BITS-1:0]  mem [DEPTH];
  logic [CNT_W-1:0]          count;
  logic                      full, ovf;
  logic                      busy, busy_nx;
  logic [IDX_BITS-1:0]       scan_idx, scan_idx_nx;
  logic                      drain_wait, drain_wait_nx;
  logic                      cmp_valid, cmp_valid_nx;
  logic signed [Z_BITS-1:0]  cmp_stub, cmp_stub_nx;
  logic [IDX_BITS-1:0]       cmp_idx, cmp_idx_nx;
  logic signed [Z_BITS-1:0]  cmp_lim_high, cmp_lim_low;
  logic                      done, done_nx;
  logic                      lim_ld;
  logic                      vld_d1;
  logic [IDX_BITS-1:0]       idx_d1;
  logic                      hit_valid, hit_nx;
  logic [IDX_BITS-1:0]       hit_idx;
  logic                      clr_ok, wr_ok, wr_bad;

  // A clear only takes effect when idle and always beats a same-cycle write
  assign clr_ok = bus.clr && !busy;
  assign wr_ok  = bus.wr_en && !full && !busy && !clr_ok;
  assign wr_bad = bus.wr_en && (full || busy) && !clr_ok;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[count[IDX_BITS-1:0]] <= bus.wr_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      full  <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr_ok) begin
      count <= '0;
      full  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (wr_ok) begin
        count <= count + CNT_W'(1);
        full  <= (count == CNT_W'(DEPTH - 1));
      end
      if (wr_bad) ovf <= 1'b1;
    end
  end

  // Scan sequencing: one stub per cycle, then a two-cycle drain ending in done
  always_comb begin
    state_nx      = state;
    busy_nx       = busy;
    scan_idx_nx   = scan_idx;
    drain_wait_nx = drain_wait;
    cmp_valid_nx  = 1'b0;
    cmp_stub_nx   = cmp_stub;
    cmp_idx_nx    = cmp_idx;
    done_nx       = 1'b0;
    lim_ld        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          lim_ld      = 1'b1;
          busy_nx     = 1'b1;
          scan_idx_nx = '0;
          if (count == CNT_W'(0)) begin
            state_nx      = DRAIN;
            drain_wait_nx = 1'b1;
          end else begin
            state_nx = SCAN;
          end
        end
      end
      SCAN: begin
        cmp_valid_nx = 1'b1;
        cmp_stub_nx  = mem[scan_idx];
        cmp_idx_nx   = scan_idx;
        scan_idx_nx  = scan_idx + IDX_BITS'(1);
        if (CNT_W'(scan_idx) == count - CNT_W'(1)) begin
          state_nx      = DRAIN;
          drain_wait_nx = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_wait) begin
          drain_wait_nx = 1'b0;
        end else begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      scan_idx     <= '0;
      drain_wait   <= 1'b0;
      cmp_valid    <= 1'b0;
      cmp_stub     <= '0;
      cmp_idx      <= '0;
      done         <= 1'b0;
      cmp_lim_high <= '0;
      cmp_lim_low  <= '0;
    end else begin
      state      <= state_nx;
      busy       <= busy_nx;
      scan_idx   <= scan_idx_nx;
      drain_wait <= drain_wait_nx;
      cmp_valid  <= cmp_valid_nx;
      cmp_stub   <= cmp_stub_nx;
      cmp_idx    <= cmp_idx_nx;
      done       <= done_nx;
      if (lim_ld) begin
        cmp_lim_high <= bus.lim_high;
        cmp_lim_low  <= bus.lim_low;
      end
    end
  end

  // Compare stage answers one cycle after cmp_valid; delay the index to meet it
  assign hit_nx = vld_d1 && bus.cmp_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_d1    <= 1'b0;
      idx_d1    <= '0;
      hit_valid <= 1'b0;
      hit_idx   <= '0;
    end else begin
      vld_d1    <= cmp_valid;
      idx_d1    <= cmp_idx;
      hit_valid <= hit_nx;
      if (hit_nx) hit_idx <= idx_d1;
    end
  end

`ifdef TS_Z_SCAN_HIT_CNT_EN
  logic [CNT_W-1:0] hit_cnt;

  // Counts alongside hit_valid so the final value is present with done
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt <= '0;
    end else if (lim_ld) begin
      hit_cnt <= '0;
    end else if (hit_nx && hit_cnt != CNT_W'(DEPTH)) begin
      hit_cnt <= hit_cnt + CNT_W'(1);
    end
  end

  assign bus.hit_cnt = hit_cnt;
`endif

  assign bus.full         = full;
  assign bus.ovf          = ovf;
  assign bus.count        = count;
  assign bus.busy         = busy;
  assign bus.cmp_valid    = cmp_valid;
  assign bus.cmp_stub     = cmp_stub;
  assign bus.cmp_lim_high = cmp_lim_high;
  assign bus.cmp_lim_low  = cmp_lim_low;
  assign bus.hit_valid    = hit_valid;
  assign bus.hit_idx      = hit_idx;
  assign bus.done         = done;
endmodule

// File: tb/tb_ts_out_stub_z_window_seq.sv
// Self-checking bench for ts_out_stub_z_window_seq with a registered window-compare model.
`timescale 1ns/1ps
module tb_ts_out_stub_z_window_seq;
  localparam int unsigned Z_BITS   = 12;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned IDX_BITS = 4;
  localparam int unsigned CNT_W    = IDX_BITS + 1;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   mdl[$];
  int   exp_stub[$];
  int   exp_hit[$];

  always #5 clk = ~clk;

  ts_out_stub_z_window_seq_if #(.Z_BITS(Z_BITS), .IDX_BITS(IDX_BITS)) bus ();

  ts_out_stub_z_window_seq #(.Z_BITS(Z_BITS), .DEPTH(DEPTH), .IDX_BITS(IDX_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Compare stage: registered signed window test
  always @(posedge clk) begin
    if (reset) bus.cmp_match <= 1'b0;
    else bus.cmp_match <= bus.cmp_valid && (bus.cmp_stub >= bus.cmp_lim_low) &&
                          (bus.cmp_stub <= bus.cmp_lim_high);
  end

  task automatic do_write(input int z);
    bus.wr_en  = 1'b1;
    bus.wr_dat = Z_BITS'(z);
    @(negedge clk);
    bus.wr_en  = 1'b0;
    if (mdl.size() < DEPTH) mdl.push_back(z);
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    mdl.delete();
  endtask

  task automatic check_buf(input string tag, input int cnt, input bit f, input bit o);
    checks++;
    if (bus.count !== CNT_W'(cnt) || bus.full !== f || bus.ovf !== o) begin
      failures++;
      $display("FAIL %s: count=%0d full=%b ovf=%b, required count=%0d full=%b ovf=%b",
               tag, bus.count, bus.full, bus.ovf, cnt, f, o);
    end
  endtask

  // Issues one start, scoreboards stubs and hits, checks done timing
  task automatic run_scan(input string tag, input int lo, input int hi, input bit disturb);
    int  n, nh, nvalid, e;
    bit  seen_done;
    n = mdl.size();
    exp_stub.delete();
    exp_hit.delete();
    foreach (mdl[i]) begin
      exp_stub.push_back(mdl[i]);
      if (mdl[i] >= lo && mdl[i] <= hi) exp_hit.push_back(i);
    end
    nh = exp_hit.size();
    bus.lim_low  = Z_BITS'(lo);
    bus.lim_high = Z_BITS'(hi);
    bus.start    = 1'b1;
    seen_done    = 1'b0;
    nvalid       = 0;
    for (int c = 1; c <= n + 8 && !seen_done; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      if (disturb && c == 2) begin
        bus.start    = 1'b1;
        bus.lim_low  = Z_BITS'(-2000);
        bus.lim_high = Z_BITS'(2000);
        bus.wr_en    = 1'b1;
        bus.wr_dat   = Z_BITS'(99);
      end
      if (bus.cmp_valid) begin
        nvalid++;
        checks++;
        if (exp_stub.size() == 0) begin
          failures++;
          $display("FAIL %s extra_cmp_valid: cycle=%0d stub=%0d, required none", tag, c, bus.cmp_stub);
        end else begin
          e = exp_stub.pop_front();
          if (bus.cmp_stub !== Z_BITS'(e) || c != nvalid + 1) begin
            failures++;
            $display("FAIL %s cmp_stub: stub=%0d cycle=%0d, required stub=%0d cycle=%0d",
                     tag, bus.cmp_stub, c, e, nvalid + 1);
          end
        end
        checks++;
        if (bus.cmp_lim_low !== Z_BITS'(lo) || bus.cmp_lim_high !== Z_BITS'(hi)) begin
          failures++;
          $display("FAIL %s cmp_lim: low=%0d high=%0d, required low=%0d high=%0d",
                   tag, bus.cmp_lim_low, bus.cmp_lim_high, lo, hi);
        end
      end
      if (bus.hit_valid) begin
        checks++;
        if (exp_hit.size() == 0) begin
          failures++;
          $display("FAIL %s extra_hit: hit_idx=%0d cycle=%0d, required none", tag, bus.hit_idx, c);
        end else begin
          e = exp_hit.pop_front();
          if (bus.hit_idx !== IDX_BITS'(e)) begin
            failures++;
            $display("FAIL %s hit_idx: got %0d, required %0d", tag, bus.hit_idx, e);
          end
        end
      end
      if (bus.done) begin
        seen_done = 1'b1;
        checks++;
        if (c != n + 3 || bus.busy !== 1'b0) begin
          failures++;
          $display("FAIL %s done: cycle=%0d busy=%b, required cycle=%0d busy=0", tag, c, bus.busy, n + 3);
        end
`ifdef TS_Z_SCAN_HIT_CNT_EN
        checks++;
        if (bus.hit_cnt !== CNT_W'(nh)) begin
          failures++;
          $display("FAIL %s hit_cnt: got %0d, required %0d", tag, bus.hit_cnt, nh);
        end
`endif
      end
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL %s timeout: done not seen within %0d cycles", tag, n + 8);
    end
    checks++;
    if (exp_stub.size() != 0 || exp_hit.size() != 0 || nvalid != n) begin
      failures++;
      $display("FAIL %s leftover: stubs_left=%0d hits_left=%0d of %0d valids=%0d, required 0 0 valids=%0d",
               tag, exp_stub.size(), exp_hit.size(), nh, nvalid, n);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.clr      = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_dat   = '0;
    bus.start    = 1'b0;
    bus.lim_high = '0;
    bus.lim_low  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.busy, bus.cmp_valid, bus.hit_valid, bus.done} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b cmp_valid=%b hit_valid=%b done=%b, required all 0",
               bus.busy, bus.cmp_valid, bus.hit_valid, bus.done);
    end
    check_buf("reset_buf", 0, 1'b0, 1'b0);
    checks++;
    if (bus.cmp_lim_high !== '0 || bus.cmp_lim_low !== '0 || bus.cmp_stub !== '0 || bus.hit_idx !== '0) begin
      failures++;
      $display("FAIL reset_data: lim_high=%0d lim_low=%0d stub=%0d hit_idx=%0d, required all 0",
               bus.cmp_lim_high, bus.cmp_lim_low, bus.cmp_stub, bus.hit_idx);
    end
  endtask

  task automatic test_basic_scan();
    do_clr();
    do_write(-5);
    do_write(0);
    do_write(7);
    do_write(20);
    check_buf("basic_load", 4, 1'b0, 1'b0);
    run_scan("basic", -2, 10, 1'b0);
  endtask

  task automatic test_empty_scan();
    do_clr();
    check_buf("empty_load", 0, 1'b0, 1'b0);
    run_scan("empty", 0, 0, 1'b0);
  endtask

  task automatic test_fill_ovf();
    do_clr();
    for (int i = 0; i < DEPTH; i++) do_write(i * 3 - 20);
    check_buf("fill_full", DEPTH, 1'b1, 1'b0);
    do_write(1);
    check_buf("fill_ovf", DEPTH, 1'b1, 1'b1);
    run_scan("fill_scan", -10, 10, 1'b0);
    do_clr();
    check_buf("fill_clr", 0, 1'b0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    do_clr();
    do_write(-100);
    do_write(3);
    do_write(4);
    do_write(500);
    run_scan("busy", 0, 10, 1'b1);
    check_buf("busy_after", 4, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_clr();
    do_write(0);
    do_write(0);
    do_write(50);
    run_scan("b2b_first", 0, 0, 1'b0);
    run_scan("b2b_second", -100, 100, 1'b0);
    check_buf("b2b_intact", 3, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    do_clr();
    for (int i = 0; i < 5; i++) do_write(i);
    bus.lim_low  = Z_BITS'(-50);
    bus.lim_high = Z_BITS'(50);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmp_valid !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_active: cmp_valid=%b busy=%b, required 1 1", bus.cmp_valid, bus.busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mdl.delete();
    checks++;
    if ({bus.busy, bus.cmp_valid, bus.hit_valid, bus.done, bus.full, bus.ovf} !== 6'b0 ||
        bus.count !== '0) begin
      failures++;
      $display("FAIL midrst_cleared: busy=%b cmp_valid=%b hit=%b done=%b count=%0d, required all 0",
               bus.busy, bus.cmp_valid, bus.hit_valid, bus.done, bus.count);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.cmp_valid, bus.hit_valid, bus.done} !== 4'b0) begin
        failures++;
        $display("FAIL midrst_quiet: cycle=%0d busy=%b cmp_valid=%b hit=%b done=%b, required all 0",
                 c, bus.busy, bus.cmp_valid, bus.hit_valid, bus.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_empty_scan();
    test_fill_ovf();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
